// File: rtl/ultrasonic_ranger_pkg.sv
// ultra_pkg: shared state encoding, mm conversion ratio and default timing for the sonar front-end.
package ultra_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;
  localparam int MM_NUM             = 17;
  localparam int MM_DEN             = 5000;
  localparam int ACC_W              = 13;
  localparam int TRIG_CYCLES_DEF    = 500;
  localparam int PERIOD_CYCLES_DEF  = 3_000_000;
  localparam int TIMEOUT_CYCLES_DEF = 1_500_000;
  localparam int OBST_THRESH_DEF    = 44117;
  localparam int DIST_W_DEF         = 12;
endpackage

// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if: sonar pins plus the registered distance/valid/obstacle result bundle.
interface ultrasonic_ranger_if
  import ultra_pkg::*;
#(
  parameter int DIST_W = DIST_W_DEF
);
  logic echo;
  logic trig;
  logic [DIST_W-1:0] dist_mm;
  logic dist_valid;
  logic obstacle;
  logic timeout;
  logic busy;
  modport master (input echo, output trig, dist_mm, dist_valid, obstacle, timeout, busy);
  modport slave (output echo, input trig, dist_mm, dist_valid, obstacle, timeout, busy);
endinterface

// File: rtl/ultrasonic_ranger_echo_sync.sv
// echo_sync: 2-flop synchroniser for the asynchronous echo pin plus rise/fall detection.
module echo_sync (
  input  logic clk0,
  input  logic rst_n,
  input  logic echo,
  output logic echo_rise,
  output logic echo_fall
);
  logic s1, s2, prev;
  always_ff @(posedge clk0 or negedge rst_n)
    if (!rst_n) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {echo, s1, s2};
  assign echo_rise = s2 & ~prev;
  assign echo_fall = ~s2 & prev;
endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: periodic HC-SR04 trigger, echo timing and divider-free width-to-mm conversion.
module ultrasonic_ranger
  import ultra_pkg::*;
#(
  parameter int TRIG_CYCLES    = TRIG_CYCLES_DEF,
  parameter int PERIOD_CYCLES  = PERIOD_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int OBST_THRESH    = OBST_THRESH_DEF,
  parameter int DIST_W         = DIST_W_DEF
) (
  input  logic clk0,
  input  logic rst_n,
  ultrasonic_ranger_if.master bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(PERIOD_CYCLES);
  localparam int MW = DIST_W + 1;
  localparam logic [DIST_W-1:0] DMAX = '1;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_inc;
  logic [PW-1:0] pcnt;
  logic [ACC_W-1:0] acc, acc_inc, acc_n;
  logic [MW-1:0] mm, mm_n;
  logic echo_rise, echo_fall, res_to, wrap;
  echo_sync u_sync (
    .clk0      (clk0),
    .rst_n     (rst_n),
    .echo      (bus.echo),
    .echo_rise (echo_rise),
    .echo_fall (echo_fall)
  );
  // cnt is shared: trigger length in TRIG, rise wait in WAIT_RISE, echo width in MEASURE
  always_comb begin
    cnt_inc = cnt + CW'(cnt != CW'(TIMEOUT_CYCLES));
    acc_inc = acc + ACC_W'(MM_NUM);
    wrap    = acc_inc >= ACC_W'(MM_DEN);
    acc_n   = wrap ? acc_inc - ACC_W'(MM_DEN) : acc_inc;
    mm_n    = mm + MW'(wrap && mm != '1);
    nxt     = state;
    res_to  = 1'b0;
    case (state)
      IDLE:      nxt = pcnt == '0 ? TRIG : IDLE;
      TRIG:      nxt = cnt == CW'(TRIG_CYCLES - 1) ? WAIT_RISE : TRIG;
      WAIT_RISE: begin
        res_to = !echo_rise && cnt == CW'(TIMEOUT_CYCLES - 1);
        nxt    = echo_rise ? MEASURE : res_to ? DONE : WAIT_RISE;
      end
      MEASURE:   begin
        res_to = !echo_fall && cnt_inc == CW'(TIMEOUT_CYCLES);
        nxt    = echo_fall || res_to ? DONE : MEASURE;
      end
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // The final MEASURE cycle is counted in cnt_inc/mm_n, so results come from the incremented values
  always_ff @(posedge clk0 or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      pcnt           <= '0;
      acc            <= '0;
      mm             <= '0;
      bus.dist_mm    <= '0;
      bus.obstacle   <= 1'b0;
      bus.timeout    <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt != state ? '0 : cnt_inc;
      pcnt  <= nxt == TRIG && state != TRIG ? PW'(PERIOD_CYCLES - 1) : pcnt - PW'(pcnt != '0);
      acc   <= nxt == MEASURE && state != MEASURE ? '0 : state == MEASURE ? acc_n : acc;
      mm    <= nxt == MEASURE && state != MEASURE ? '0 : state == MEASURE ? mm_n : mm;
      if (nxt == DONE) begin
        bus.dist_mm  <= res_to || mm_n > MW'(DMAX) ? DMAX : mm_n[DIST_W-1:0];
        bus.obstacle <= !res_to && int'(cnt_inc) <= OBST_THRESH;
        bus.timeout  <= res_to;
      end
    end
  assign bus.trig       = state == TRIG;
  assign bus.dist_valid = state == DONE;
  assign bus.busy       = state != IDLE;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: randomized echo widths against an arithmetic distance model, scaled timing.
module tb_ultrasonic_ranger;
  localparam int TRIG   = 10;
  localparam int PERIOD = 5200;
  localparam int TMO    = 2500;
  localparam int OBST   = 1000;
  localparam int DW     = 3;
  localparam logic [DW-1:0] DMAX = '1;
  logic clk0 = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  ultrasonic_ranger_if #(.DIST_W(DW)) bus ();
  ultrasonic_ranger #(
    .TRIG_CYCLES    (TRIG),
    .PERIOD_CYCLES  (PERIOD),
    .TIMEOUT_CYCLES (TMO),
    .OBST_THRESH    (OBST),
    .DIST_W         (DW)
  ) dut (
    .clk0  (clk0),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk0 = ~clk0;
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // Expected result for an echo held high for n clock samples
  function automatic void model(input int n, output logic [DW-1:0] d, output logic o, output logic t);
    longint mm;
    t  = n > TMO;
    mm = longint'(n) * 17 / 5000;
    d  = t || mm > longint'(DMAX) ? DMAX : mm[DW-1:0];
    o  = !t && n <= OBST;
  endfunction
  task automatic wait_trig_fall(output bit ok);
    int k = 0;
    bit seen;
    while (bus.trig !== 1'b1 && k < PERIOD + 100) begin @(posedge clk0); #1; k++; end
    seen = bus.trig === 1'b1;
    while (bus.trig !== 1'b0 && k < PERIOD + 200) begin @(posedge clk0); #1; k++; end
    ok = seen && bus.trig === 1'b0;
  endtask
  task automatic run_echo(input int n, output int lat, output logic [DW-1:0] d, output logic o,
                          output logic t, output bit ok, output bit one_pulse);
    bit f;
    wait_trig_fall(f);
    repeat ($urandom_range(1, 30)) @(posedge clk0);
    #1 bus.echo = 1'b1;
    repeat (n) @(posedge clk0);
    #1 bus.echo = 1'b0;
    lat = 0;
    while (bus.dist_valid !== 1'b1 && lat < TMO + 20) begin @(posedge clk0); #1; lat++; end
    ok = f && bus.dist_valid === 1'b1;
    d = bus.dist_mm;
    o = bus.obstacle;
    t = bus.timeout;
    @(posedge clk0);
    #1 one_pulse = bus.dist_valid === 1'b0;
  endtask
  task automatic test_reset();
    bus.echo = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk0);
    #1;
    checks++; if (bus.trig !== 1'b0) begin fails++; $display("FAIL rst_trig: got %b want 0", bus.trig); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.dist_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.dist_valid); end
    checks++; if (bus.dist_mm !== '0) begin fails++; $display("FAIL rst_dist: got %0d want 0", bus.dist_mm); end
    checks++; if (bus.obstacle !== 1'b0) begin fails++; $display("FAIL rst_obst: got %b want 0", bus.obstacle); end
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b want 0", bus.timeout); end
    @(negedge clk0) rst_n = 1'b1;
  endtask
  task automatic test_trig_no_echo();
    int cyc = 0, fall_at = -1, val_at = -1, rise_at = -1;
    logic [DW-1:0] vd = '0;
    logic vo = 1'bx, vt = 1'bx;
    @(posedge clk0);
    #1;
    checks++; if (bus.trig !== 1'b1) begin fails++; $display("FAIL trig_first_edge: got %b want 1", bus.trig); end
    while (rise_at < 0 && cyc < PERIOD + 50) begin
      @(posedge clk0);
      #1;
      cyc++;
      if (fall_at < 0 && bus.trig === 1'b0) fall_at = cyc;
      else if (fall_at >= 0 && bus.trig === 1'b1) rise_at = cyc;
      if (bus.dist_valid === 1'b1) begin val_at = cyc; vd = bus.dist_mm; vo = bus.obstacle; vt = bus.timeout; end
    end
    checks++; if (fall_at != TRIG) begin fails++; $display("FAIL trig_width: got %0d want %0d", fall_at, TRIG); end
    checks++; if (val_at != TRIG + TMO) begin fails++; $display("FAIL noecho_latency: got %0d want %0d", val_at, TRIG + TMO); end
    checks++; if (rise_at != PERIOD) begin fails++; $display("FAIL trig_period: got %0d want %0d", rise_at, PERIOD); end
    checks++; if (vd !== DMAX) begin fails++; $display("FAIL noecho_dist: got %0d want %0d", vd, DMAX); end
    checks++; if (vt !== 1'b1) begin fails++; $display("FAIL noecho_timeout: got %b want 1", vt); end
    checks++; if (vo !== 1'b0) begin fails++; $display("FAIL noecho_obst: got %b want 0", vo); end
  endtask
  task automatic test_widths();
    int ws[$] = {294, 295, OBST, OBST + 1, TMO, TMO + 1};
    int lat;
    logic [DW-1:0] d, ed;
    logic o, t, eo, et;
    bit ok, p1;
    repeat (3) ws.push_back(int'($urandom_range(1, TMO)));
    foreach (ws[i]) begin
      run_echo(ws[i], lat, d, o, t, ok, p1);
      model(ws[i], ed, eo, et);
      checks++; if (!ok) begin fails++; $display("FAIL w%0d_valid: no dist_valid within bound", ws[i]); end
      if (!et) begin
        checks++; if (lat != 3) begin fails++; $display("FAIL w%0d_latency: got %0d want 3", ws[i], lat); end
      end
      checks++; if (d !== ed) begin fails++; $display("FAIL w%0d_dist: got %0d want %0d", ws[i], d, ed); end
      checks++; if (o !== eo) begin fails++; $display("FAIL w%0d_obst: got %b want %b", ws[i], o, eo); end
      checks++; if (t !== et) begin fails++; $display("FAIL w%0d_timeout: got %b want %b", ws[i], t, et); end
      checks++; if (!p1) begin fails++; $display("FAIL w%0d_pulse: dist_valid got 1 want 0 on next cycle", ws[i]); end
    end
  endtask
  task automatic test_stuck_echo();
    int k = 0, lat = 0;
    logic [DW-1:0] d, ed;
    logic o, t, eo, et;
    bit ok, p1;
    while (bus.trig !== 1'b1 && k < PERIOD + 100) begin @(posedge clk0); #1; k++; end
    repeat (3) @(posedge clk0);
    #1 bus.echo = 1'b1;
    while (bus.trig !== 1'b0 && k < PERIOD + 200) begin @(posedge clk0); #1; k++; end
    while (bus.dist_valid !== 1'b1 && lat < TMO + 20) begin @(posedge clk0); #1; lat++; end
    checks++; if (lat != TMO) begin fails++; $display("FAIL stuck_latency: got %0d want %0d", lat, TMO); end
    checks++; if (bus.timeout !== 1'b1) begin fails++; $display("FAIL stuck_timeout: got %b want 1", bus.timeout); end
    checks++; if (bus.dist_mm !== DMAX) begin fails++; $display("FAIL stuck_dist: got %0d want %0d", bus.dist_mm, DMAX); end
    checks++; if (bus.obstacle !== 1'b0) begin fails++; $display("FAIL stuck_obst: got %b want 0", bus.obstacle); end
    bus.echo = 1'b0;
    run_echo(500, lat, d, o, t, ok, p1);
    model(500, ed, eo, et);
    checks++; if (!ok) begin fails++; $display("FAIL after_stuck_valid: no dist_valid within bound"); end
    checks++; if (lat != 3) begin fails++; $display("FAIL after_stuck_latency: got %0d want 3", lat); end
    checks++; if (d !== ed) begin fails++; $display("FAIL after_stuck_dist: got %0d want %0d", d, ed); end
    checks++; if (o !== eo) begin fails++; $display("FAIL after_stuck_obst: got %b want %b", o, eo); end
    checks++; if (t !== et) begin fails++; $display("FAIL after_stuck_timeout: got %b want %b", t, et); end
  endtask
  task automatic test_reset_mid_measure();
    bit ok;
    int seen_valid = 0;
    wait_trig_fall(ok);
    repeat (5) @(posedge clk0);
    #1 bus.echo = 1'b1;
    repeat (100) @(posedge clk0);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.trig !== 1'b0) begin fails++; $display("FAIL midrst_trig: got %b want 0", bus.trig); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.dist_mm !== '0) begin fails++; $display("FAIL midrst_dist: got %0d want 0", bus.dist_mm); end
    checks++; if (bus.obstacle !== 1'b0) begin fails++; $display("FAIL midrst_obst: got %b want 0", bus.obstacle); end
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL midrst_timeout: got %b want 0", bus.timeout); end
    repeat (5) begin
      @(posedge clk0);
      #1 if (bus.dist_valid !== 1'b0) seen_valid++;
    end
    bus.echo = 1'b0;
    checks++; if (seen_valid != 0) begin fails++; $display("FAIL midrst_valid: got %0d pulses want 0", seen_valid); end
    @(negedge clk0) rst_n = 1'b1;
    @(posedge clk0);
    #1;
    checks++; if (bus.trig !== 1'b1) begin fails++; $display("FAIL midrst_retrig: got %b want 1", bus.trig); end
    checks++; if (bus.dist_valid !== 1'b0) begin fails++; $display("FAIL midrst_post_valid: got %b want 0", bus.dist_valid); end
  endtask
  initial begin
    test_reset();
    test_trig_no_echo();
    test_widths();
    test_stuck_echo();
    test_reset_mid_measure();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
